// File: rtl/conv1d_pkg.sv
// Shared constants for the conv1d CFU: command codes, lane widths and the
// drain STATUS word layout.
package conv1d_pkg;

    localparam int BYTE_SIZE  = 8;
    localparam int INT32_SIZE = 32;
    localparam int CMD_W      = 7;
    localparam int LANES      = INT32_SIZE / BYTE_SIZE;

    // Codes 0-15 belong to the existing conv1d ops.
    localparam logic [CMD_W-1:0] CMD_DRAIN_POP    = 7'd16;
    localparam logic [CMD_W-1:0] CMD_DRAIN_STATUS = 7'd17;
    localparam logic [CMD_W-1:0] CMD_DRAIN_FLUSH  = 7'd18;
    localparam logic [CMD_W-1:0] CMD_DRAIN_CLEAR  = 7'd19;

    localparam int STAT_COUNT_LSB     = 0;
    localparam int STAT_COUNT_W       = 5;
    localparam int STAT_LANE_LSB      = 8;
    localparam int STAT_EMPTY_BIT     = 12;
    localparam int STAT_FULL_BIT      = 13;
    localparam int STAT_UNDERFLOW_BIT = 14;
    localparam int STAT_OVERFLOW_BIT  = 15;

    function automatic logic [INT32_SIZE-1:0] pack_status(
        input logic                    overflow,
        input logic                    underflow,
        input logic                    full,
        input logic                    empty,
        input logic [1:0]              lane,
        input logic [STAT_COUNT_W-1:0] count
    );
        logic [INT32_SIZE-1:0] s;
        s = '0;
        s[STAT_OVERFLOW_BIT]                   = overflow;
        s[STAT_UNDERFLOW_BIT]                  = underflow;
        s[STAT_FULL_BIT]                       = full;
        s[STAT_EMPTY_BIT]                      = empty;
        s[STAT_LANE_LSB +: 2]                  = lane;
        s[STAT_COUNT_LSB +: STAT_COUNT_W]      = count;
        return s;
    endfunction

endpackage

// File: rtl/conv1d_result_drain_if.sv
// CFU command bus plus the quant-stage result handshake seen by the drain.
interface conv1d_result_drain_if;
    import conv1d_pkg::*;

    logic                  en;
    logic [CMD_W-1:0]      cmd;
    logic [INT32_SIZE-1:0] inp0;
    logic [INT32_SIZE-1:0] inp1;
    logic [INT32_SIZE-1:0] ret;
    logic                  res_valid;
    logic [INT32_SIZE-1:0] res_data;
    logic                  res_ready;
    logic                  words_avail;

    modport master (
        output en, cmd, inp0, inp1, res_valid, res_data,
        input  ret, res_ready, words_avail
    );

    modport slave (
        input  en, cmd, inp0, inp1, res_valid, res_data,
        output ret, res_ready, words_avail
    );

endinterface

// File: rtl/sync_word_fifo.sv
// Single-clock circular word FIFO. Read data is the head entry; the consumer
// registers it, so the array maps onto distributed RAM with one write port.
module sync_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // Fullness is judged on the pre-pop count, so a full FIFO refuses a push
    // even when a pop happens on the same edge.
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/conv1d_result_drain.sv
// Packs int8 quant results four per word (lane 0 in the low byte), queues the
// words and lets the CPU pop, inspect, flush or clear them via CFU commands.
module conv1d_result_drain
    import conv1d_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv1d_result_drain_if.slave   bus
);

    logic [INT32_SIZE-1:0]   pack_q, pack_d;
    logic [1:0]              lane_q, lane_d;
    logic [INT32_SIZE-1:0]   ret_q, ret_d;
    logic                    underflow_q, underflow_d;
    logic                    overflow_q, overflow_d;

    logic [INT32_SIZE-1:0]   merged;
    logic [INT32_SIZE-1:0]   rd_data;
    logic [BYTE_SIZE-1:0]    in_byte;
    logic [PTR_W:0]          count;
    logic [STAT_COUNT_W-1:0] count_field;
    logic                    full, empty;
    logic                    accept, push, pop, fifo_clr;
    logic                    cmd_pop, cmd_status, cmd_flush, cmd_clear;
    logic                    unused_bits;

    assign unused_bits = ^{bus.inp0, bus.inp1[INT32_SIZE-1:1],
                           bus.res_data[INT32_SIZE-1:BYTE_SIZE]};

    assign in_byte         = bus.res_data[BYTE_SIZE-1:0];
    assign accept          = bus.res_valid && !full;
    assign bus.res_ready   = !full;
    assign bus.words_avail = !empty;
    assign bus.ret         = ret_q;

    assign cmd_pop    = bus.en && (bus.cmd == CMD_DRAIN_POP);
    assign cmd_status = bus.en && (bus.cmd == CMD_DRAIN_STATUS);
    assign cmd_flush  = bus.en && (bus.cmd == CMD_DRAIN_FLUSH);
    assign cmd_clear  = bus.en && (bus.cmd == CMD_DRAIN_CLEAR);

    // Pack register with the incoming byte already merged into its lane; this
    // is both the next partial word and the word pushed on completion/flush.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign merged[gi*BYTE_SIZE +: BYTE_SIZE] =
            (accept && (lane_q == 2'(gi))) ? in_byte
                                            : pack_q[gi*BYTE_SIZE +: BYTE_SIZE];
    end

    if (PTR_W + 1 >= STAT_COUNT_W) begin : g_cnt_trunc
        assign count_field = count[STAT_COUNT_W-1:0];
    end else begin : g_cnt_ext
        assign count_field = {{(STAT_COUNT_W - PTR_W - 1){1'b0}}, count};
    end

    always_comb begin
        pack_d      = pack_q;
        lane_d      = lane_q;
        ret_d       = ret_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        push        = 1'b0;
        pop         = 1'b0;
        fifo_clr    = 1'b0;

        if (accept) begin
            if (lane_q == 2'd3) begin
                push   = 1'b1;
                pack_d = '0;
                lane_d = 2'd0;
            end else begin
                pack_d = merged;
                lane_d = lane_q + 1'b1;
            end
        end

        // Flush sees the lane after any same-edge accept: a completing byte
        // leaves nothing to flush, an earlier byte rides along in merged.
        if (cmd_flush) begin
            ret_d = '0;
            ret_d[PTR_W:0] = count;
            if (lane_d != 2'd0) begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
                pack_d = '0;
                lane_d = 2'd0;
            end
        end

        if (cmd_pop) begin
            if (!empty) begin
                ret_d = rd_data;
                pop   = 1'b1;
            end else begin
                ret_d       = '0;
                underflow_d = 1'b1;
            end
        end

        if (cmd_status) begin
            ret_d = pack_status(overflow_q, underflow_q, full, empty,
                                lane_q, count_field);
        end

        if (cmd_clear) begin
            ret_d = '0;
            if (bus.inp1[0]) begin
                fifo_clr    = 1'b1;
                push        = 1'b0;
                pop         = 1'b0;
                pack_d      = '0;
                lane_d      = 2'd0;
                underflow_d = 1'b0;
                overflow_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q      <= '0;
            lane_q      <= 2'd0;
            ret_q       <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            pack_q      <= pack_d;
            lane_q      <= lane_d;
            ret_q       <= ret_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_word_fifo #(
        .WIDTH (INT32_SIZE),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (fifo_clr),
        .push    (push),
        .wr_data (merged),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule

// File: tb/tb_conv1d_result_drain.sv
// Directed and randomized checks of the result drain against a queue-based
// model of packed words, pending bytes and sticky error flags.
module tb_conv1d_result_drain;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [31:0] q[$];
    logic [7:0]  part[$];
    logic        uf;
    logic        of;
    logic [31:0] exp_ret;

    conv1d_result_drain_if bus();

    conv1d_result_drain #(
        .FIFO_DEPTH (16),
        .PTR_W      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] part_word();
        logic [31:0] w;
        w = '0;
        foreach (part[k]) w = w | (32'(part[k]) << (8 * k));
        return w;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [4:0] cnt;
        cnt = 5'(q.size());
        return {16'b0, of, uf, (q.size() == 16), (q.size() == 0), 2'b0,
                2'(part.size()), 3'b0, cnt};
    endfunction

    task automatic model_reset();
        q.delete();
        part.delete();
        uf      = 1'b0;
        of      = 1'b0;
        exp_ret = '0;
    endtask

    // One clock edge of behaviour, evaluated from the pre-edge model state.
    task automatic model_step(input logic v, input logic [7:0] b, input logic e,
                              input logic [6:0] c, input logic [31:0] i1);
        int n;
        bit full0;
        bit do_pop;
        n      = q.size();
        full0  = (n == 16);
        do_pop = 1'b0;
        if (e && c == 7'd19) begin
            exp_ret = '0;
            if (i1[0]) begin
                q.delete();
                part.delete();
                uf = 1'b0;
                of = 1'b0;
                return;
            end
        end
        if (e && c == 7'd17) exp_ret = exp_status();
        if (e && c == 7'd18) exp_ret = 32'(n);
        if (e && c == 7'd16) begin
            if (n > 0) begin
                exp_ret = q[0];
                do_pop  = 1'b1;
            end else begin
                exp_ret = '0;
                uf      = 1'b1;
            end
        end
        if (v && !full0) part.push_back(b);
        if (part.size() == 4) begin
            q.push_back(part_word());
            part.delete();
        end else if (e && c == 7'd18 && part.size() > 0) begin
            if (full0) of = 1'b1;
            else q.push_back(part_word());
            part.delete();
        end
        if (do_pop) void'(q.pop_front());
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic e,
                        input logic [6:0] c, input logic [31:0] i1, input string tag);
        bus.res_valid = v;
        bus.res_data  = {24'($urandom()), b};
        bus.en        = e;
        bus.cmd       = c;
        bus.inp0      = $urandom();
        bus.inp1      = i1;
        check({tag, ".ready_pre"}, 32'(bus.res_ready), 32'(q.size() < 16));
        @(posedge clk);
        model_step(v, b, e, c, i1);
        #1;
        check({tag, ".ret"}, bus.ret, exp_ret);
        check({tag, ".avail"}, 32'(bus.words_avail), 32'(q.size() != 0));
        check({tag, ".ready"}, 32'(bus.res_ready), 32'(q.size() < 16));
    endtask

    task automatic acc(input logic [7:0] b);
        step(1'b1, b, 1'b0, 7'd0, 32'd0, "acc");
    endtask

    task automatic cmd(input logic [6:0] c, input logic [31:0] i1);
        step(1'b0, 8'd0, 1'b1, c, i1, "cmd");
    endtask

    initial begin
        logic [31:0] w;
        int          r;
        int          popw;
        logic [6:0]  rc;
        total = 0;
        bad   = 0;
        model_reset();
        bus.en = 1'b0; bus.cmd = '0; bus.inp0 = '0; bus.inp1 = '0;
        bus.res_valid = 1'b0; bus.res_data = '0;

        rst_n = 1'b0;
        #12;
        check("reset.ret", bus.ret, 32'd0);
        check("reset.ready", 32'(bus.res_ready), 32'd1);
        check("reset.avail", 32'(bus.words_avail), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic four-byte pack and pop
        acc(8'h11); acc(8'h22); acc(8'hF0); acc(8'h7F);
        cmd(7'd16, 32'd0);
        check("pop_basic", bus.ret, 32'h7FF0_2211);
        cmd(7'd17, 32'd0);
        check("status_after_pop", bus.ret, 32'h0000_1000);

        // Partial word flush
        acc(8'h05); acc(8'h06);
        cmd(7'd18, 32'd0);
        check("flush_ret", bus.ret, 32'd0);
        cmd(7'd16, 32'd0);
        check("pop_flushed", bus.ret, 32'h0000_0605);
        cmd(7'd17, 32'd0);
        check("status_after_flush", bus.ret, 32'h0000_1000);

        // Fill to full with valid held, 65th byte refused
        for (int k = 0; k < 65; k++) step(1'b1, 8'(k), 1'b0, 7'd0, 32'd0, "fill");
        check("full_ready", 32'(bus.res_ready), 32'd0);
        cmd(7'd17, 32'd0);
        check("status_full", bus.ret, 32'h0000_2010);
        for (int k = 0; k < 16; k++) begin
            cmd(7'd16, 32'd0);
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            check($sformatf("drain_word%0d", k), bus.ret, w);
        end

        // Underflow and clear
        cmd(7'd16, 32'd0);
        check("pop_empty", bus.ret, 32'd0);
        cmd(7'd17, 32'd0);
        check("status_underflow", bus.ret, 32'h0000_5000);
        cmd(7'd19, 32'd1);
        cmd(7'd17, 32'd0);
        check("status_cleared", bus.ret, 32'h0000_1000);

        // Completion and pop on the same edge at count=3
        for (int k = 0; k < 15; k++) acc(8'(8'h30 + k));
        step(1'b1, 8'h3F, 1'b1, 7'd16, 32'd0, "acc_pop");
        check("acc_pop_word", bus.ret, 32'h3332_3130);
        cmd(7'd17, 32'd0);
        check("status_acc_pop", bus.ret, 32'h0000_0003);

        // Asynchronous reset with lane=2, count=5
        for (int k = 0; k < 10; k++) acc(8'(8'hA0 + k));
        cmd(7'd17, 32'd0);
        check("status_pre_reset", bus.ret, 32'h0000_0205);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset.ret", bus.ret, 32'd0);
        check("async_reset.ready", 32'(bus.res_ready), 32'd1);
        check("async_reset.avail", 32'(bus.words_avail), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd(7'd17, 32'd0);
        check("status_post_reset", bus.ret, 32'h0000_1000);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            popw = (i < 200) ? 1 : 7;
            r    = $urandom_range(0, 19);
            if (r < popw)        rc = 7'd16;
            else if (r < 10)     rc = 7'd17;
            else if (r < 15)     rc = 7'd18;
            else if (r == 15)    rc = 7'd19;
            else                 rc = 7'($urandom_range(0, 15));
            step($urandom_range(0, 2) != 0, 8'($urandom()),
                 $urandom_range(0, 3) != 0, rc, $urandom(), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
